// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples SCLK/CS/SDI on clk, receives one FRAME_W-bit word per
// CS-low window and shifts out a preloaded reply word, MSB first.
module spi_responder #(
   parameter int FRAME_W     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               SCLK,
   input  logic               CS,
   input  logic               SDI,
   output logic               SDO,
   input  logic [FRAME_W-1:0] tx_data,
   input  logic               tx_load,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic               rx_ack,
   output logic               busy,
   output logic               overrun,
   output logic               frame_err,
   input  logic               clr_err,
   output logic [1:0]         state_dbg
);

   localparam int CW = $clog2(FRAME_W + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Handshake: rx_valid rises when a complete word lands in rx_data and stays high until
   // rx_ack is sampled high; a new word in the same cycle as rx_ack keeps rx_valid high.

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sdi_sync;

   logic [1:0]         state;
   logic [FRAME_W-1:0] tx_hold;
   logic [FRAME_W-1:0] tx_shift;
   logic [FRAME_W-1:0] rx_shift;
   logic [CW-1:0]      count;
   logic               start_pend;

   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;
   logic sdi_bit;
   logic frame_done;
   logic frame_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         sdi_sync  <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      end
   end

   // Edges compare the two oldest synchronizer stages.
   assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
   assign cs_rise   = cs_sync[SYNC_STAGES-2] & ~cs_sync[SYNC_STAGES-1];
   assign cs_fall   = ~cs_sync[SYNC_STAGES-2] & cs_sync[SYNC_STAGES-1];
   assign sdi_bit   = sdi_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_hold <= '0;
      end else if (tx_load) begin
         tx_hold <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         tx_shift   <= '0;
         rx_shift   <= '0;
         count      <= '0;
         start_pend <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cs_fall || start_pend) begin
                  start_pend <= 1'b0;
                  tx_shift   <= tx_hold;
                  rx_shift   <= '0;
                  count      <= '0;
                  state      <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // CS rise wins; any SCLK edge seen in the same cycle is dropped.
               if (cs_rise) begin
                  state <= S_DONE;
               end else if (sclk_rise) begin
                  rx_shift <= {rx_shift[FRAME_W-2:0], sdi_bit};
                  if (count != CNT_SAT) begin
                     count <= count + 1'b1;
                  end
               end else if (sclk_fall) begin
                  tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
               end
            end
            S_DONE: begin
               start_pend <= cs_fall;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign frame_done = (state == S_DONE);
   assign frame_ok   = frame_done && (count == CNT_FULL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (frame_ok) begin
            rx_data <= rx_shift;
         end

         if (frame_ok) begin
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end

         // Error sets take priority over clr_err in the same cycle.
         if (frame_ok && rx_valid && !rx_ack) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end

         if (frame_done && !frame_ok) begin
            frame_err <= 1'b1;
         end else if (clr_err) begin
            frame_err <= 1'b0;
         end
      end
   end

   assign busy      = (state == S_SHIFT);
   assign SDO       = busy & tx_shift[FRAME_W-1];
   assign state_dbg = state;

endmodule
